// File: rtl/registered_gate_bank.sv
// Registered bank of bitwise AND, OR, NOT a and NOT b of two operand vectors,
// plus one opcode-selected result, all captured one clock after in_valid.
module registered_gate_bank #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_or,
  output logic [WIDTH-1:0] out_not_a,
  output logic [WIDTH-1:0] out_not_b,
  output logic [WIDTH-1:0] out_sel,
  output logic             out_valid
);

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_NOT_A = 2'b10;
  localparam logic [1:0] OP_NOT_B = 2'b11;

  logic [WIDTH-1:0] and_c;
  logic [WIDTH-1:0] or_c;
  logic [WIDTH-1:0] not_a_c;
  logic [WIDTH-1:0] not_b_c;
  logic [WIDTH-1:0] sel_c;

  logic [WIDTH-1:0] out_and_d,   out_and_q;
  logic [WIDTH-1:0] out_or_d,    out_or_q;
  logic [WIDTH-1:0] out_not_a_d, out_not_a_q;
  logic [WIDTH-1:0] out_not_b_d, out_not_b_q;
  logic [WIDTH-1:0] out_sel_d,   out_sel_q;
  logic             out_valid_d, out_valid_q;

  // Pure bitwise functions; no cross-bit interaction.
  always_comb begin
    and_c   = a & b;
    or_c    = a | b;
    not_a_c = ~a;
    not_b_c = ~b;
    sel_c   = and_c;
    case (op)
      OP_AND:   sel_c = and_c;
      OP_OR:    sel_c = or_c;
      OP_NOT_A: sel_c = not_a_c;
      OP_NOT_B: sel_c = not_b_c;
      default:  sel_c = and_c;
    endcase
  end

  // Capture on in_valid; otherwise results hold and out_valid drops.
  always_comb begin
    out_and_d   = out_and_q;
    out_or_d    = out_or_q;
    out_not_a_d = out_not_a_q;
    out_not_b_d = out_not_b_q;
    out_sel_d   = out_sel_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_and_d   = and_c;
      out_or_d    = or_c;
      out_not_a_d = not_a_c;
      out_not_b_d = not_b_c;
      out_sel_d   = sel_c;
      out_valid_d = 1'b1;
    end
  end

  // Synchronous reset wins over a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_and_q   <= '0;
      out_or_q    <= '0;
      out_not_a_q <= '0;
      out_not_b_q <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_and_q   <= out_and_d;
      out_or_q    <= out_or_d;
      out_not_a_q <= out_not_a_d;
      out_not_b_q <= out_not_b_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_and   = out_and_q;
  assign out_or    = out_or_q;
  assign out_not_a = out_not_a_q;
  assign out_not_b = out_not_b_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_registered_gate_bank.sv
// Bench for registered_gate_bank: an 8-bit and a 1-bit instance sharing control,
// checked against a per-bit arithmetic model of the logic functions.
module tb_registered_gate_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;

  logic [7:0] d8_and, d8_or, d8_na, d8_nb, d8_sel;
  logic       d8_valid;
  logic [0:0] d1_and, d1_or, d1_na, d1_nb, d1_sel;
  logic       d1_valid;

  logic [7:0] m8_and, m8_or, m8_na, m8_nb, m8_sel;
  logic       m8_valid;
  logic [0:0] m1_and, m1_or, m1_na, m1_nb, m1_sel;
  logic       m1_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  registered_gate_bank #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .op(op),
    .out_and(d8_and), .out_or(d8_or), .out_not_a(d8_na), .out_not_b(d8_nb),
    .out_sel(d8_sel), .out_valid(d8_valid)
  );

  registered_gate_bank #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .op(op),
    .out_and(d1_and), .out_or(d1_or), .out_not_a(d1_na), .out_not_b(d1_nb),
    .out_sel(d1_sel), .out_valid(d1_valid)
  );

  wire logic [40:0] got8 = {d8_and, d8_or, d8_na, d8_nb, d8_sel, d8_valid};
  wire logic [40:0] exp8 = {m8_and, m8_or, m8_na, m8_nb, m8_sel, m8_valid};
  wire logic [5:0]  got1 = {d1_and, d1_or, d1_na, d1_nb, d1_sel, d1_valid};
  wire logic [5:0]  exp1 = {m1_and, m1_or, m1_na, m1_nb, m1_sel, m1_valid};

  // Function f of operands x,y per bit, using 0/1 arithmetic: 0 AND, 1 OR, 2 NOT x, 3 NOT y.
  function automatic logic [7:0] ref_fn(input int f, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    int xi, yi;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      xi = int'(x[i]);
      yi = int'(y[i]);
      case (f)
        0:       r[i] = 1'(xi * yi);
        1:       r[i] = 1'(xi + yi - xi * yi);
        2:       r[i] = 1'(1 - xi);
        default: r[i] = 1'(1 - yi);
      endcase
    end
    return r;
  endfunction

  // Advance one clock, apply the capture/hold/reset rules to the model, settle.
  task automatic tick();
    logic [7:0] x1, y1;
    @(posedge clk);
    x1 = {7'b0, a1};
    y1 = {7'b0, b1};
    if (rst) begin
      {m8_and, m8_or, m8_na, m8_nb, m8_sel} = '0;
      {m1_and, m1_or, m1_na, m1_nb, m1_sel} = '0;
      m8_valid = 1'b0;
      m1_valid = 1'b0;
    end else if (in_valid) begin
      m8_and = ref_fn(0, a8, b8);  m8_or = ref_fn(1, a8, b8);
      m8_na  = ref_fn(2, a8, b8);  m8_nb = ref_fn(3, a8, b8);
      m8_sel = ref_fn(int'(op), a8, b8);
      m1_and = 1'(ref_fn(0, x1, y1));  m1_or = 1'(ref_fn(1, x1, y1));
      m1_na  = 1'(ref_fn(2, x1, y1));  m1_nb = 1'(ref_fn(3, x1, y1));
      m1_sel = 1'(ref_fn(int'(op), x1, y1));
      m8_valid = 1'b1;
      m1_valid = 1'b1;
    end else begin
      m8_valid = 1'b0;
      m1_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1; op = 2'b10;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (got8 !== 41'h0) begin
        errors++; $display("FAIL reset_w8 cyc%0d got %h expected %h", c, got8, 41'h0);
      end
      checks++;
      if (got1 !== 6'h0) begin
        errors++; $display("FAIL reset_w1 cyc%0d got %b expected %b", c, got1, 6'h0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [3:0] expv [4];
    expv[0] = 4'b0011; expv[1] = 4'b0110; expv[2] = 4'b0101; expv[3] = 4'b1100;
    in_valid = 1'b1; op = 2'b00;
    for (int v = 0; v < 4; v++) begin
      a1 = 1'(v >> 1); b1 = 1'(v & 1);
      a8 = {8{a1}};    b8 = {8{b1}};
      tick();
      checks++;
      if ({d1_and, d1_or, d1_na, d1_nb, d1_valid} !== {expv[v], 1'b1}) begin
        errors++;
        $display("FAIL truth_w1 ab=%0d%0d got %b expected %b", a1, b1,
                 {d1_and, d1_or, d1_na, d1_nb, d1_valid}, {expv[v], 1'b1});
      end
      checks++;
      if (got8 !== exp8) begin
        errors++; $display("FAIL truth_w8 v=%0d got %h expected %h", v, got8, exp8);
      end
    end
  endtask

  task automatic test_opcode_select();
    logic [3:0] exp_sel;
    exp_sel = 4'b1010;  // sel for op 3..0 with a=1, b=0
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; a8 = 8'h5A; b8 = 8'h3C;
    for (int o = 0; o < 4; o++) begin
      op = 2'(o);
      tick();
      checks++;
      if (d1_sel !== exp_sel[o]) begin
        errors++; $display("FAIL opsel_w1 op=%0d got %b expected %b", o, d1_sel, exp_sel[o]);
      end
      checks++;
      if (got8 !== exp8) begin
        errors++; $display("FAIL opsel_w8 op=%0d got %h expected %h", o, got8, exp8);
      end
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hA5; b8 = 8'h0F; op = 2'b00;
    tick();
    in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'hFF; op = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (got1 !== 6'b110010) begin
        errors++; $display("FAIL hold_w1 cyc%0d got %b expected %b", c, got1, 6'b110010);
      end
      checks++;
      if (got8 !== {8'h05, 8'hAF, 8'h5A, 8'hF0, 8'h05, 1'b0}) begin
        errors++; $display("FAIL hold_w8 cyc%0d got %h expected %h", c, got8,
                           {8'h05, 8'hAF, 8'h5A, 8'hF0, 8'h05, 1'b0});
      end
    end
  endtask

  task automatic test_wide();
    in_valid = 1'b1; a8 = 8'hF0; b8 = 8'hCC; op = 2'b11; a1 = 1'b0; b1 = 1'b1;
    tick();
    checks++;
    if ({d8_and, d8_or, d8_na, d8_nb, d8_sel, d8_valid} !== {8'hC0, 8'hFC, 8'h0F, 8'h33, 8'h33, 1'b1}) begin
      errors++; $display("FAIL wide_w8 got %h expected %h", got8,
                         {8'hC0, 8'hFC, 8'h0F, 8'h33, 8'h33, 1'b1});
    end
  endtask

  task automatic test_reset_mid_stream();
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rst = (c == 4);
      a8 = 8'($urandom); b8 = 8'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      op = 2'($urandom);
      tick();
      checks++;
      if (c == 4 && got8 !== 41'h0) begin
        errors++; $display("FAIL midrst_w8 got %h expected %h", got8, 41'h0);
      end else if (c != 4 && got8 !== exp8) begin
        errors++; $display("FAIL stream_w8 cyc%0d got %h expected %h", c, got8, exp8);
      end
      checks++;
      if (got1 !== exp1) begin
        errors++; $display("FAIL stream_w1 cyc%0d got %b expected %b", c, got1, exp1);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 300; c++) begin
      in_valid = (c < 100) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      op = 2'($urandom);
      tick();
      checks++;
      if (got8 !== exp8) begin
        errors++; $display("FAIL b2b_w8 cyc%0d got %h expected %h", c, got8, exp8);
      end
      checks++;
      if (got1 !== exp1) begin
        errors++; $display("FAIL b2b_w1 cyc%0d got %b expected %b", c, got1, exp1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_opcode_select();
    test_hold();
    test_wide();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
